// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the scalar register-file writeback path.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int WB_N_REQ   = 3;

    localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: N packed valid/addr/data lanes with a one-hot ready back.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_REQ  = WB_N_REQ,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) ();

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);

endinterface

// File: rtl/regfile_wb_arbiter_wb_rr_arbiter.sv
// N-way writeback arbiter. Round-robin when WB_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module wb_rr_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] valid,
    input  logic             accept,
    output logic [N_REQ-1:0] grant
);

`ifdef WB_ARB_RR_EN
    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_idx;
    logic             found;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        grant   = '0;
        win_idx = ptr_q;
        found   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'((int'(ptr_q) + k) % N_REQ);
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_idx    = idx;
            end
        end
    end

    always_comb begin
        ptr_d = accept ? win_idx : ptr_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= IDX_W'(N_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_arb_inputs;
    assign unused_arb_inputs = ^{clock, reset, accept};

    always_comb begin
        grant = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard and RAW query.
// Arbitration policy is selected by WB_ARB_RR_EN (see wb_rr_arbiter).
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_REQ  = WB_N_REQ,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  req,
    output logic                 wen,
    output logic [ADDR_W-1:0]    wa,
    output logic [DATA_W-1:0]    wd,
    input  logic                 rsv_valid,
    input  logic [ADDR_W-1:0]    rsv_addr,
    output logic                 rsv_conflict,
    input  logic [ADDR_W-1:0]    qa,
    input  logic [ADDR_W-1:0]    qb,
    output logic                 busy_a,
    output logic                 busy_b
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(X0_ADDR);

    logic [N_REQ-1:0]  grant;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [NREG-1:0]   mask_q, mask_d;

    wb_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clock  (clock),
        .reset  (reset),
        .valid  (req.req_valid),
        .accept (accept),
        .grant  (grant)
    );

    assign req.req_ready = grant & {N_REQ{~reset}};
    assign accept        = |(req.req_valid & req.req_ready);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // x0 writes complete the handshake but never reach the register file.
    always_comb begin
        wen_d = accept && (sel_addr != ZERO_ADDR);
        wa_d  = accept ? sel_addr : wa_q;
        wd_d  = accept ? sel_data : wd_q;
    end

    // Set after clear, so a same-cycle reservation of the written register wins.
    always_comb begin
        mask_d = mask_q;
        if (wen_q) begin
            mask_d[wa_q] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != ZERO_ADDR)) begin
            mask_d[rsv_addr] = 1'b1;
        end
        mask_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wen_q  <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            mask_q <= '0;
        end else begin
            wen_q  <= wen_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            mask_q <= mask_d;
        end
    end

    assign wen = wen_q;
    assign wa  = wa_q;
    assign wd  = wd_q;

    // A register written this cycle is already visible through the file's bypass.
    assign busy_a       = mask_q[qa] & ~(wen_q & (wa_q == qa));
    assign busy_b       = mask_q[qb] & ~(wen_q & (wa_q == qb));
    assign rsv_conflict = rsv_valid & mask_q[rsv_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed checks of regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int N  = WB_N_REQ;
    localparam int AW = REG_ADDR_W;
    localparam int DW = REG_DATA_W;
    localparam int NR = 1 << AW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    regfile_wb_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    logic          wen;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rsv_valid;
    logic [AW-1:0] rsv_addr;
    logic          rsv_conflict;
    logic [AW-1:0] qa, qb;
    logic          busy_a, busy_b;

    logic          va [N];
    logic [AW-1:0] aa [N];
    logic [DW-1:0] da [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign bus.req_valid[gi]            = va[gi];
        assign bus.req_addr[gi*AW +: AW]    = aa[gi];
        assign bus.req_data[gi*DW +: DW]    = da[gi];
    end

    regfile_wb_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (bus),
        .wen          (wen),
        .wa           (wa),
        .wd           (wd),
        .rsv_valid    (rsv_valid),
        .rsv_addr     (rsv_addr),
        .rsv_conflict (rsv_conflict),
        .qa           (qa),
        .qb           (qb),
        .busy_a       (busy_a),
        .busy_b       (busy_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: pending-register set, expected write-port contents, last winner.
    bit            mask_m [NR];
    bit            exp_wen;
    logic [AW-1:0] exp_wa;
    logic [DW-1:0] exp_wd;
    int            last_m;
    int            gidx;

    function automatic int pick();
`ifdef WB_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last_m + k) % N;
            if (va[j]) return j;
        end
`else
        for (int j = 0; j < N; j++) begin
            if (va[j]) return j;
        end
`endif
        return -1;
    endfunction

    task automatic reset_model();
        for (int r = 0; r < NR; r++) mask_m[r] = 1'b0;
        exp_wen = 1'b0;
        exp_wa  = '0;
        exp_wd  = '0;
        last_m  = N - 1;
    endtask

    task automatic check_in_reset();
        check_eq("rst_ready", bus.req_ready, '0);
        check_eq("rst_wen", wen, 0);
        check_eq("rst_wa", wa, 0);
        check_eq("rst_wd", wd, 0);
        check_eq("rst_busy_a", busy_a, 0);
        check_eq("rst_busy_b", busy_b, 0);
        check_eq("rst_conflict", rsv_conflict, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_in_reset();
        reset_model();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        @(negedge clock);
        g = pick();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("ready", bus.req_ready, exp_rdy);
        check_eq("wen", wen, exp_wen);
        if (exp_wen) begin
            check_eq("wa", wa, exp_wa);
            check_eq("wd", wd, exp_wd);
        end
        check_eq("busy_a", busy_a, mask_m[qa] && !(exp_wen && exp_wa == qa));
        check_eq("busy_b", busy_b, mask_m[qb] && !(exp_wen && exp_wa == qb));
        if (!(exp_wen && exp_wa == rsv_addr))
            check_eq("conflict", rsv_conflict, rsv_valid && mask_m[rsv_addr]);
        if (g >= 0)
            $display("xfer req%0d addr=%0d data=%08h", g, aa[g], da[g]);
        @(posedge clock);
        if (exp_wen) mask_m[exp_wa] = 1'b0;
        if (rsv_valid && rsv_addr != 0) mask_m[rsv_addr] = 1'b1;
        exp_wen = (g >= 0) && (aa[g] != 0);
        if (g >= 0) begin
            exp_wa = aa[g];
            exp_wd = da[g];
            last_m = g;
        end
        gidx = g;
        #1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) va[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            va[i] = 1'b0;
            aa[i] = '0;
            da[i] = '0;
        end
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        qa        = '0;
        qb        = '0;
        reset_model();
        repeat (2) @(posedge clock);
        #1;
        check_in_reset();
        reset = 1'b0;

        // Single write to r5.
        va[0] = 1'b1; aa[0] = 5; da[0] = 32'hDEADBEEF;
        cycle();
        check_eq("t1_grant", gidx, 0);
        check_eq("t1_wen", wen, 1);
        check_eq("t1_wa", wa, 5);
        check_eq("t1_wd", wd, 32'hDEADBEEF);
        va[0] = 1'b0;
        cycle();
        check_eq("t1_wen_off", wen, 0);

        // All requesters continuously valid from a fresh reset.
        do_reset();
        for (int i = 0; i < N; i++) begin
            va[i] = 1'b1; aa[i] = AW'(10 + i); da[i] = $urandom;
        end
        for (int r = 0; r < 2 * N; r++) begin
            int exp_g;
`ifdef WB_ARB_RR_EN
            exp_g = r % N;
`else
            exp_g = 0;
`endif
            cycle();
            check_eq("t2_grant", gidx, exp_g);
            if (gidx >= 0) da[gidx] = $urandom;
        end
        clear_reqs();
        cycle();

        // Write to x0 is accepted but never reaches the file.
        va[1] = 1'b1; aa[1] = 0; da[1] = 32'h1234; qa = 0;
        cycle();
        check_eq("t3_grant", gidx, 1);
        check_eq("t3_wen", wen, 0);
        va[1] = 1'b0;
        cycle();

        // Reserve r7, observe busy, then write it back.
        rsv_valid = 1'b1; rsv_addr = 7; qa = 7;
        cycle();
        rsv_valid = 1'b0;
        check_eq("t4_busy_set", busy_a, 1);
        cycle();
        va[2] = 1'b1; aa[2] = 7; da[2] = $urandom;
        cycle();
        va[2] = 1'b0;
        check_eq("t4_busy_bypass", busy_a, 0);
        cycle();
        check_eq("t4_busy_clear", busy_a, 0);
        cycle();

        // Same-cycle reserve and write of r9, then re-reserve while busy.
        rsv_valid = 1'b1; rsv_addr = 9;
        cycle();
        rsv_valid = 1'b0;
        va[0] = 1'b1; aa[0] = 9; da[0] = $urandom;
        cycle();
        va[0] = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 9; qa = 9;
        cycle();
        rsv_valid = 1'b0;
        check_eq("t5_bit_kept", busy_a, 1);
        rsv_valid = 1'b1; rsv_addr = 9;
        #1;
        check_eq("t5_conflict", rsv_conflict, 1);
        cycle();
        rsv_valid = 1'b0;

        // Randomized traffic over a small register pool so clears and conflicts occur.
        for (int r = 0; r < 400; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!va[i] && $urandom_range(0, 2) == 0) begin
                    va[i] = 1'b1;
                    aa[i] = AW'($urandom_range(0, 7));
                    da[i] = $urandom;
                end
            end
            rsv_valid = ($urandom_range(0, 3) == 0);
            rsv_addr  = AW'($urandom_range(0, 7));
            qa        = ($urandom_range(0, 3) == 0) ? exp_wa : AW'($urandom_range(0, 7));
            qb        = AW'($urandom_range(0, 7));
            cycle();
            if (gidx >= 0) va[gidx] = 1'b0;
        end
        clear_reqs();
        rsv_valid = 1'b0;

        // Reset while a write is on the port and three registers are reserved.
        do_reset();
        rsv_valid = 1'b1;
        rsv_addr = 3; cycle();
        rsv_addr = 4; cycle();
        rsv_addr = 6; cycle();
        rsv_valid = 1'b0;
        qa = 3; qb = 4;
        va[0] = 1'b1; aa[0] = 3; da[0] = $urandom;
        va[1] = 1'b1; aa[1] = 4; da[1] = $urandom;
        cycle();
        check_eq("t7_wen_before", wen, 1);
        do_reset();
        cycle();
        check_eq("t7_regrant", gidx, 0);
        clear_reqs();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
